// File: rtl/divider_post.sv
// Sign/divide-by-zero correction for the last divider stage, followed by a
// first-word-fall-through result FIFO with occupancy, almost-full and sticky overflow.
module divider_post #(
    parameter int N_DIVIDEND = 32,
    parameter int N_DIVISOR  = 32,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [N_DIVIDEND-1:0]      i_quotient,
    input  logic [N_DIVISOR-1:0]       i_remainder,
    input  logic [N_DIVISOR-1:0]       i_divisor,
    input  logic                       i_div_signed,
    input  logic                       i_dividend_signed,
    input  logic                       i_divisor_signed,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [N_DIVIDEND-1:0]      o_quotient,
    output logic [N_DIVISOR-1:0]       o_remainder,
    output logic                       o_dbz,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_afull,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N_DIVIDEND-1:0] q_c;
    logic [N_DIVISOR-1:0]  r_c;
    logic                  dbz_c;

    logic [N_DIVIDEND-1:0] mem_q   [DEPTH];
    logic [N_DIVISOR-1:0]  mem_r   [DEPTH];
    logic                  mem_dbz [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          full, pop, push_ok, overflow;
    logic          afull;

    // Remainder always takes the dividend sign, even on divide-by-zero.
    always_comb begin
        dbz_c = (i_divisor == '0);
        q_c   = i_quotient;
        if (i_div_signed && (i_dividend_signed ^ i_divisor_signed))
            q_c = -i_quotient;
        if (dbz_c)
            q_c = '1;
        r_c = (i_div_signed && i_dividend_signed) ? -i_remainder : i_remainder;
    end

    assign full      = (count == CW'(DEPTH));
    assign pop       = o_valid && i_ready;
    // A full FIFO can still accept when the head leaves on the same edge.
    assign push_ok   = i_valid && (!full || pop);
    assign count_nxt = count + CW'(push_ok) - CW'(pop);

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr]   <= q_c;
            mem_r[wr_ptr]   <= r_c;
            mem_dbz[wr_ptr] <= dbz_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            afull    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (i_valid && !push_ok)
                overflow <= 1'b1;
            count <= count_nxt;
            afull <= (count_nxt >= CW'(AFULL_LVL));
        end
    end

    // Storage is not reset; gating by valid keeps the head at zero when empty.
    assign o_valid     = (count != '0);
    assign o_quotient  = o_valid ? mem_q[rd_ptr]   : '0;
    assign o_remainder = o_valid ? mem_r[rd_ptr]   : '0;
    assign o_dbz       = o_valid ? mem_dbz[rd_ptr] : 1'b0;
    assign o_count     = count;
    assign o_afull     = afull;
    assign o_overflow  = overflow;

endmodule

// File: tb/tb_divider_post.sv
// Self-checking bench for divider_post: directed vector table, full/overflow and
// reset sequences, then randomized traffic against a signed-arithmetic reference.
module tb_divider_post;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_quotient, i_remainder, i_divisor;
    logic        i_div_signed, i_dividend_signed, i_divisor_signed;
    logic        o_valid, i_ready;
    logic [31:0] o_quotient, o_remainder;
    logic        o_dbz;
    logic [2:0]  o_count;
    logic        o_afull, o_overflow;

    divider_post dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_quotient(i_quotient), .i_remainder(i_remainder), .i_divisor(i_divisor),
        .i_div_signed(i_div_signed), .i_dividend_signed(i_dividend_signed),
        .i_divisor_signed(i_divisor_signed), .o_valid(o_valid), .i_ready(i_ready),
        .o_quotient(o_quotient), .o_remainder(o_remainder), .o_dbz(o_dbz),
        .o_count(o_count), .o_afull(o_afull), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] q, r, d;
        logic        sg, ds, vs;
        logic [31:0] eq, er;
        logic        edbz;
    } vec_t;

    typedef struct {
        logic [31:0] q, r;
        logic        dbz;
    } res_t;

    int   checks = 0;
    int   failures = 0;
    res_t mq[$];
    res_t cur_exp;
    logic movf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_raw(input logic [31:0] q, input logic [31:0] r, input logic [31:0] d,
                             input logic sg, input logic ds, input logic vs);
        i_quotient = q; i_remainder = r; i_divisor = d;
        i_div_signed = sg; i_dividend_signed = ds; i_divisor_signed = vs;
    endtask

    // Builds divider-stage inputs from original operands; the expected result is
    // plain signed/unsigned arithmetic (truncating division, remainder takes dividend sign).
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sg);
        logic [31:0] ma, mb, iq, ir;
        longint      la, lb;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        if (mb == 0) begin
            iq = '1; ir = ma;
            cur_exp = '{q: 32'hFFFF_FFFF, r: a, dbz: 1'b1};
        end else begin
            iq = ma / mb; ir = ma % mb;
            la = sg ? longint'($signed(a)) : longint'(a);
            lb = sg ? longint'($signed(b)) : longint'(b);
            cur_exp = '{q: 32'(la / lb), r: 32'(la % lb), dbz: 1'b0};
        end
        drive_raw(iq, ir, mb, sg, a[31], b[31]);
    endtask

    task automatic cycle_model();
        bit pop, push;
        pop  = (mq.size() > 0) && i_ready;
        push = i_valid;
        if (push && mq.size() == 4 && !pop) movf = 1'b1;
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(cur_exp);
        end
        tick();
        chk("rnd_count", o_count, mq.size());
        chk("rnd_valid", o_valid, mq.size() > 0);
        chk("rnd_afull", o_afull, mq.size() >= 2);
        chk("rnd_ovf", o_overflow, movf);
        if (mq.size() > 0) begin
            chk("rnd_q", o_quotient, mq[0].q);
            chk("rnd_r", o_remainder, mq[0].r);
            chk("rnd_dbz", o_dbz, mq[0].dbz);
        end
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{q: 14, r: 2, d: 7, sg: 0, ds: 0, vs: 0, eq: 14, er: 2, edbz: 0};
        tbl[1] = '{q: 3, r: 1, d: 2, sg: 1, ds: 1, vs: 0, eq: 32'hFFFF_FFFD, er: 32'hFFFF_FFFF, edbz: 0};
        tbl[2] = '{q: 3, r: 1, d: 2, sg: 1, ds: 0, vs: 1, eq: 32'hFFFF_FFFD, er: 1, edbz: 0};
        tbl[3] = '{q: 32'hFFFF_FFFF, r: 5, d: 0, sg: 0, ds: 0, vs: 0, eq: 32'hFFFF_FFFF, er: 5, edbz: 1};
        tbl[4] = '{q: 3, r: 1, d: 2, sg: 1, ds: 1, vs: 1, eq: 3, er: 32'hFFFF_FFFF, edbz: 0};
        tbl[5] = '{q: 7, r: 5, d: 0, sg: 1, ds: 1, vs: 1, eq: 32'hFFFF_FFFF, er: 32'hFFFF_FFFB, edbz: 1};

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        drive_raw(0, 0, 1, 0, 0, 0);
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_afull", o_afull, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_q", o_quotient, 0);
        i_rst_n = 1'b1;
        tick();

        foreach (tbl[k]) begin
            drive_raw(tbl[k].q, tbl[k].r, tbl[k].d, tbl[k].sg, tbl[k].ds, tbl[k].vs);
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            chk($sformatf("vec%0d_valid", k), o_valid, 1);
            chk($sformatf("vec%0d_q", k), o_quotient, tbl[k].eq);
            chk($sformatf("vec%0d_r", k), o_remainder, tbl[k].er);
            chk($sformatf("vec%0d_dbz", k), o_dbz, tbl[k].edbz);
            chk($sformatf("vec%0d_count", k), o_count, 1);
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            chk($sformatf("vec%0d_drain", k), o_count, 0);
        end

        // Fill past full with the consumer stalled.
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_raw(k, 0, 1, 0, 0, 0);
            i_valid = 1'b1;
            tick();
            chk("fill_head", o_quotient, 1);
        end
        i_valid = 1'b0;
        chk("full_count", o_count, 4);
        chk("full_afull", o_afull, 1);
        chk("full_ovf", o_overflow, 1);
        tick();
        chk("stall_head", o_quotient, 1);
        // Push and pop together while full.
        drive_raw(6, 0, 1, 0, 0, 0);
        i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0; i_ready = 1'b0;
        chk("pushpop_count", o_count, 4);
        chk("pushpop_head", o_quotient, 2);
        begin
            logic [31:0] order[4];
            order = '{2, 3, 4, 6};
            for (int k = 0; k < 4; k++) begin
                chk("drain_head", o_quotient, order[k]);
                i_ready = 1'b1;
                tick();
            end
        end
        chk("drain_count", o_count, 0);
        chk("drain_valid", o_valid, 0);
        chk("drain_afull", o_afull, 0);
        tick();
        chk("underflow_count", o_count, 0);
        i_ready = 1'b0;

        // Mid-cycle reset with entries stored.
        for (int k = 0; k < 3; k++) begin
            drive_raw(20 + k, 0, 1, 0, 0, 0);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        chk("pre_rst_count", o_count, 3);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_afull", o_afull, 0);
        chk("mid_rst_ovf", o_overflow, 0);
        chk("mid_rst_q", o_quotient, 0);
        chk("mid_rst_r", o_remainder, 0);
        chk("mid_rst_dbz", o_dbz, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive_raw(9, 0, 1, 0, 0, 0);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("post_rst_valid", o_valid, 1);
        chk("post_rst_q", o_quotient, 9);
        chk("post_rst_count", o_count, 1);

        // Randomized traffic against the arithmetic reference.
        mq.delete();
        movf = 1'b0;
        cur_exp = '{q: 9, r: 0, dbz: 1'b0};
        mq.push_back(cur_exp);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = $urandom_range(1, 9);
                2: b = -$urandom_range(1, 9);
                default: b = $urandom;
            endcase
            drive_op(a, b, 1'($urandom_range(0, 1)));
            i_valid = ($urandom_range(0, 9) < 6);
            i_ready = ($urandom_range(0, 9) < ((n < 1500) ? 5 : 7));
            if (n == 2000) begin
                i_rst_n = 1'b0;
                #1;
                i_rst_n = 1'b1;
                mq.delete();
                movf = 1'b0;
            end
            cycle_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
